// File: rtl/tt_um_vga_mandala.sv
// VGA 640x480@60 timing generator with an 8-fold symmetric animated mandala on a TinyVGA PMOD.
// Optional MANDALA_ANIM_EN enables the frame counter; without it the pattern is static.
module tt_um_vga_mandala #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned CX     = 320,
    parameter int unsigned CY     = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SS    = H_VIS + H_FP;
    localparam int unsigned H_SE    = H_SS + H_SYNC;
    localparam int unsigned V_SS    = V_VIS + V_FP;
    localparam int unsigned V_SE    = V_SS + V_SYNC;

    logic [CW-1:0]        h, v;
    logic [7:0]           frame;
    logic                 frame_end;
    logic signed [CW:0]   dx, dy;
    logic [CW-1:0]        ax, ay, hi, lo, r, d;
    logic [5:0]           c;
    logic [1:0]           rr, gg, bb;
    logic                 vis, hs, vs;
    logic [7:0]           uo_q;
    logic                 unused;

    assign frame_end = (h == CW'(H_TOTAL - 1)) && (v == CW'(V_TOTAL - 1));

    // Raster position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == CW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == CW'(V_TOTAL - 1)) ? '0 : v + CW'(1);
        end else begin
            h <= h + CW'(1);
        end
    end

`ifdef MANDALA_ANIM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (frame_end && !ui_in[2]) begin
            frame <= frame + 8'd1;
        end
    end
    assign unused = &{1'b0, ena, uio_in, ui_in[7:3], r[9], r[2:0], d[9:8], d[1:0], frame[7:6]};
`else
    assign frame  = '0;
    assign unused = &{1'b0, ena, uio_in, ui_in[7:2], r[9], r[2:0], d[9:8], d[1:0], frame[7:6],
                      frame_end};
`endif

    // Octant folding: distance-like radius and diagonal offset from the centre
    always_comb begin
        dx = (CW+1)'({1'b0, h}) - (CW+1)'(CX);
        dy = (CW+1)'({1'b0, v}) - (CW+1)'(CY);
        ax = dx[CW] ? CW'(-dx) : CW'(dx);
        ay = dy[CW] ? CW'(-dy) : CW'(dy);
        hi = (ax > ay) ? ax : ay;
        lo = (ax > ay) ? ay : ax;
        r  = hi + {1'b0, lo[CW-1:1]};
        d  = hi - lo;
        c  = (r[8:3] + frame[5:0]) ^ d[7:2];
    end

    // Palette, blanking and sync decode
    always_comb begin
        rr  = c[5:4];
        gg  = c[3:2];
        bb  = c[1:0];
        vis = (h < CW'(H_VIS)) && (v < CW'(V_VIS));
        hs  = !((h >= CW'(H_SS)) && (h < CW'(H_SE)));
        vs  = !((v >= CW'(V_SS)) && (v < CW'(V_SE)));
        case (ui_in[1:0])
            2'b01: begin
                rr = ~c[5:4];
                gg = ~c[3:2];
                bb = ~c[1:0];
            end
            2'b10: begin
                rr = c[3:2];
                gg = c[1:0];
                bb = c[5:4];
            end
            2'b11: begin
                gg = c[5:4];
                bb = c[5:4];
            end
            default: ;
        endcase
        if (!vis) begin
            rr = '0;
            gg = '0;
            bb = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_q <= 8'h88;
        end else begin
            uo_q <= {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_vga_mandala.sv
// Bench for tt_um_vga_mandala: a full-size instance plus a short-frame instance (few lines per
// frame, centre row 2) so frame-level behaviour fits in a short run; both checked every cycle.
module tb_tt_um_vga_mandala;

    localparam int HT  = 800;
    localparam int SVV = 4;
    localparam int SVF = 1;
    localparam int SVS = 2;
    localparam int SVB = 1;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int SCY = 2;
`ifdef MANDALA_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_b, uio_out_b, uio_oe_b;
    logic [7:0] uo_s, uio_out_s, uio_oe_s;

    always #5 clk = ~clk;

    tt_um_vga_mandala dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b)
    );

    tt_um_vga_mandala #(
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CY(SCY)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_s), .uio_out(uio_out_s), .uio_oe(uio_oe_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pixel value from the pattern rules, in plain integer arithmetic
    function automatic logic [7:0] pix(input int h, input int v, input int fr, input logic [7:0] ui,
                                       input int vvis, input int vsl, input int cy);
        int ax, ay, hi, lo, r, d, c;
        logic [1:0] rr, gg, bb, t;
        logic hs, vs;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= vsl && v < vsl + 2);
        rr = 2'b00; gg = 2'b00; bb = 2'b00;
        if (h < 640 && v < vvis) begin
            ax = (h >= 320) ? h - 320 : 320 - h;
            ay = (v >= cy) ? v - cy : cy - v;
            hi = (ax > ay) ? ax : ay;
            lo = (ax > ay) ? ay : ax;
            r  = (hi + lo / 2) % 1024;
            d  = (hi - lo) % 1024;
            c  = (((r / 8) % 64 + fr % 64) % 64) ^ ((d / 4) % 64);
            rr = 2'(c / 16);
            gg = 2'((c / 4) % 4);
            bb = 2'(c % 4);
            case (ui[1:0])
                2'd1: begin rr = 2'd3 - rr; gg = 2'd3 - gg; bb = 2'd3 - bb; end
                2'd2: begin t = rr; rr = gg; gg = bb; bb = t; end
                2'd3: begin gg = rr; bb = rr; end
                default: ;
            endcase
        end
        return {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
    endfunction

    // Reference: linear pixel index per instance, frame number, and expected registered output
    int t_b = 0, t_s = 0, fr_b = 0, fr_s = 0;
    logic [7:0] exp_b = 8'h00, exp_s = 8'h00;
    bit mdl_ok = 1'b0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            t_b <= 0; t_s <= 0; fr_b <= 0; fr_s <= 0;
            exp_b <= 8'h88; exp_s <= 8'h88;
            mdl_ok <= 1'b1;
        end else begin
            exp_b <= pix(t_b % HT, t_b / HT, fr_b, ui_in, 480, 490, 240);
            exp_s <= pix(t_s % HT, t_s / HT, fr_s, ui_in, SVV, SVV + SVF, SCY);
            if (ANIM && !ui_in[2] && t_b == HT * 525 - 1) fr_b <= (fr_b + 1) % 256;
            if (ANIM && !ui_in[2] && t_s == HT * SVT - 1) fr_s <= (fr_s + 1) % 256;
            t_b <= (t_b + 1) % (HT * 525);
            t_s <= (t_s + 1) % (HT * SVT);
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            check("uo_full", uo_b, exp_b);
            check("uo_short", uo_s, exp_s);
            check("uio_zero", {uio_out_b, uio_oe_b, uio_out_s, uio_oe_s}, 32'h0);
        end
    end

    // Sync edge monitor: full-size hsync and short-frame vsync
    bit mon_en = 1'b0;
    logic hb_prev, vs_prev;
    int hb_fall, vs_fall, hb_edges, vs_edges;

    always @(negedge clk) begin
        if (mon_en) begin
            if (uo_b[7] != hb_prev) begin
                hb_edges++;
                if (!uo_b[7]) begin
                    if (hb_fall >= 0) check("hsync_period", cyc - hb_fall, HT);
                    hb_fall = cyc;
                end else if (hb_fall >= 0) begin
                    check("hsync_low", cyc - hb_fall, 96);
                end
            end
            if (uo_s[3] != vs_prev) begin
                vs_edges++;
                if (!uo_s[3]) begin
                    if (vs_fall >= 0) check("vsync_period", cyc - vs_fall, HT * SVT);
                    vs_fall = cyc;
                end else if (vs_fall >= 0) begin
                    check("vsync_low", cyc - vs_fall, HT * SVS);
                end
            end
            hb_prev = uo_b[7];
            vs_prev = uo_s[3];
        end
    end

    task automatic rnd_ui(input logic [7:0] mask, input logic [7:0] val);
        ui_in  = (8'($urandom) & ~mask) | (val & mask);
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance with random inputs until the short instance is about to show pixel (hh,vv)
    task automatic wait_small(input int hh, input int vv, input logic [7:0] mask, input logic [7:0] val);
        int n = 0;
        while (t_s != vv * HT + hh && n < 20000) begin
            rnd_ui(mask, val);
            @(negedge clk);
            n++;
        end
        check("wait_position", t_s, vv * HT + hh);
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [7:0] ui;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int n;
        vecs[0]  = '{320, 2, 8'h00, 8'h88};
        vecs[1]  = '{320, 2, 8'h01, 8'hFF};
        vecs[2]  = '{320, 2, 8'h06, 8'h88};
        vecs[3]  = '{700, 2, 8'h01, 8'h08};
        vecs[4]  = '{100, 6, 8'h00, 8'h80};
        vecs[5]  = '{328, 2, 8'h00, 8'hCC};
        vecs[6]  = '{328, 2, 8'h01, 8'hBB};
        vecs[7]  = '{328, 2, 8'h02, 8'hAA};
        vecs[8]  = '{480, 2, 8'h00, 8'hBB};
        vecs[9]  = '{480, 2, 8'h03, 8'hFF};
        vecs[10] = '{340, 0, 8'h00, 8'hAC};
        vecs[11] = '{639, 3, 8'h00, 8'h8B};
        vecs[12] = '{640, 3, 8'h00, 8'h88};
        vecs[13] = '{0,   4, 8'h00, 8'h88};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            do_reset();
            wait_small(vecs[i].h, vecs[i].v, 8'h00, 8'h00);
            ui_in = vecs[i].ui;
            @(negedge clk);
            check($sformatf("vec%0d", i), uo_s, vecs[i].exp);
        end

        // Mid-frame reset: outputs return to idle, hsync restarts from the line start
        do_reset();
        wait_small(200, 3, 8'h00, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_uo_full", uo_b, 8'h88);
        check("reset_uo_short", uo_s, 8'h88);
        rst_n = 1'b1;
        @(negedge clk);
        n = 0;
        while (uo_b[7] && n < 2000) begin
            rnd_ui(8'h00, 8'h00);
            @(negedge clk);
            n++;
        end
        check("hsync_after_reset", n, 656);

        // Pause for three frames, then resume; also measure sync timing meanwhile
        do_reset();
        ui_in    = 8'h04;
        hb_prev  = 1'b1; vs_prev = 1'b1;
        hb_fall  = -1;   vs_fall = -1;
        hb_edges = 0;    vs_edges = 0;
        mon_en   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_small(400, 2, 8'h04, 8'h04);
            ui_in = 8'h04;
            @(negedge clk);
            check($sformatf("paused_frame%0d", k), uo_s, 8'hBE);
        end
        wait_small(400, 2, 8'h04, 8'h00);
        ui_in = 8'h00;
        @(negedge clk);
        check("resumed_pixel", uo_s, ANIM ? 8'hFE : 8'hBE);
        mon_en = 1'b0;
        check("hsync_edges_seen", hb_edges >= 50, 1);
        check("vsync_edges_seen", vs_edges >= 6, 1);

        // Free-running random inputs, including the pause bit across frame ends
        do_reset();
        for (int i = 0; i < 9000; i++) begin
            rnd_ui(8'h00, 8'h00);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
